// File: rtl/ribm_solver_pipe.sv
// ribm_solver_pipe: riBM key-equation solver, one iteration per cycle, with
// valid/ready I/O and a one-entry result buffer. Option: RIBM_ZERO_BYPASS_EN.
module ribm_solver_pipe #(
    parameter int            T     = 11,
    parameter int            W     = 10,
    parameter logic [W-1:0]  POLY  = 10'h009,
    parameter int            KW    = 6,
    parameter int            TAG_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [(2*T+1)*W-1:0]       syn_i,
    input  logic [TAG_W-1:0]           tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [(T+1)*W-1:0]         sigma_o,
    output logic [T*W-1:0]             omega_o,
    output logic [$clog2(T+1)-1:0]     deg_o,
    output logic                       zero_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);

    localparam int N  = 2 * T;
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(T + 1);
    localparam logic [(T+1)*W-1:0] SIG_ONE = {{(T*W){1'b0}}, {(W-1){1'b0}}, 1'b1};
`ifdef RIBM_ZERO_BYPASS_EN
    localparam bit ZB_EN = 1'b1;
`else
    localparam bit ZB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, ZBYP} state_e;

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] p;
        logic [W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p ^ x;
            x = x[W-1] ? ({x[W-2:0], 1'b0} ^ POLY) : {x[W-2:0], 1'b0};
        end
        return p;
    endfunction

    state_e state_q, state_d;

    logic [W-1:0]     lam_q [0:T];
    logic [W-1:0]     lam_d [0:T];
    logic [W-1:0]     b_q   [0:T];
    logic [W-1:0]     b_d   [0:T];
    logic [W-1:0]     dlt_q [0:N-1];
    logic [W-1:0]     dlt_d [0:N-1];
    logic [W-1:0]     tht_q [0:N-1];
    logic [W-1:0]     tht_d [0:N-1];
    logic [W-1:0]     gam_q, gam_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             zro_q, zro_d;

    logic [W-1:0]     lam_it [0:T];
    logic [W-1:0]     dlt_it [0:N-1];
    logic [(T+1)*W-1:0] sig_it;
    logic [T*W-1:0]   om_it;
    logic [DW-1:0]    deg_it;

    logic [(T+1)*W-1:0] osig_q, osig_d;
    logic [T*W-1:0]   oom_q, oom_d;
    logic [DW-1:0]    odeg_q, odeg_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             ozro_q, ozro_d;
    logic             ovld_q, ovld_d;

    logic cond, accept, adv, wr_run, wr_zb, buf_free, last, syn_zero;
    logic unused_syn0;

    assign unused_syn0 = ^syn_i[W-1:0];
    assign syn_zero    = (syn_i[(N+1)*W-1:W] == '0);
    assign buf_free    = !ovld_q || out_ready_i;
    assign last        = (cnt_q == CW'(N - 1));
    assign accept      = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (ZB_EN && syn_zero) ? ZBYP : RUN;
            RUN:     if (wr_run) state_d = IDLE;
            ZBYP:    if (wr_zb)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        adv        = 1'b0;
        wr_run     = 1'b0;
        wr_zb      = 1'b0;
        unique case (state_q)
            IDLE: in_ready_o = !rst_i;
            RUN: begin
                busy_o = 1'b1;
                adv    = !last || buf_free;
                wr_run = last && buf_free;
            end
            ZBYP: begin
                busy_o = 1'b1;
                wr_zb  = buf_free;
            end
            default: ;
        endcase
    end

    // Systolic PE outputs for the current iteration
    always_comb begin
        cond      = (dlt_q[0] != '0) && !k_q[KW-1];
        lam_it[0] = gf_mul(gam_q, lam_q[0]);
        for (int i = 1; i <= T; i++)
            lam_it[i] = gf_mul(gam_q, lam_q[i]) ^ gf_mul(dlt_q[0], b_q[i-1]);
        for (int j = 0; j < N - 1; j++)
            dlt_it[j] = gf_mul(gam_q, dlt_q[j+1]) ^ gf_mul(dlt_q[0], tht_q[j]);
        dlt_it[N-1] = gf_mul(dlt_q[0], tht_q[N-1]);
    end

    always_comb begin
        sig_it = '0;
        om_it  = '0;
        deg_it = '0;
        for (int i = 0; i <= T; i++) sig_it[i*W +: W] = lam_it[i];
        for (int i = 1; i <= T; i++)
            if (lam_it[i] != '0) deg_it = DW'(i);
        for (int j = 0; j < T; j++) om_it[j*W +: W] = dlt_it[j];
    end

    always_comb begin
        lam_d = lam_q;
        b_d   = b_q;
        dlt_d = dlt_q;
        tht_d = tht_q;
        gam_d = gam_q;
        k_d   = k_q;
        cnt_d = cnt_q;
        tag_d = tag_q;
        zro_d = zro_q;
        if (accept) begin
            for (int q = 0; q < N; q++) begin
                dlt_d[q] = syn_i[(q+1)*W +: W];
                tht_d[q] = syn_i[(q+1)*W +: W];
            end
            for (int i = 0; i <= T; i++) begin
                lam_d[i] = '0;
                b_d[i]   = '0;
            end
            lam_d[0] = W'(1);
            b_d[0]   = W'(1);
            gam_d    = W'(1);
            k_d      = '0;
            cnt_d    = '0;
            tag_d    = tag_i;
            zro_d    = syn_zero;
        end else if (adv) begin
            lam_d = lam_it;
            dlt_d = dlt_it;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (cond) begin
                b_d = lam_q;
                for (int j = 0; j < N - 1; j++) tht_d[j] = dlt_q[j+1];
                tht_d[N-1] = '0;
                gam_d      = dlt_q[0];
                k_d        = ~k_q;
            end else begin
                b_d[0] = '0;
                for (int i = 1; i <= T; i++) b_d[i] = b_q[i-1];
                k_d = k_q + KW'(1);
            end
        end
    end

    // A write on the same edge as a drain keeps the buffer full
    always_comb begin
        osig_d = osig_q;
        oom_d  = oom_q;
        odeg_d = odeg_q;
        otag_d = otag_q;
        ozro_d = ozro_q;
        ovld_d = ovld_q;
        if (wr_run) begin
            osig_d = sig_it;
            oom_d  = om_it;
            odeg_d = deg_it;
            otag_d = tag_q;
            ozro_d = zro_q;
            ovld_d = 1'b1;
        end else if (wr_zb) begin
            osig_d = SIG_ONE;
            oom_d  = '0;
            odeg_d = '0;
            otag_d = tag_q;
            ozro_d = 1'b1;
            ovld_d = 1'b1;
        end else if (out_ready_i) begin
            ovld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i <= T; i++) begin
                lam_q[i] <= (i == 0) ? W'(1) : '0;
                b_q[i]   <= (i == 0) ? W'(1) : '0;
            end
            for (int j = 0; j < N; j++) begin
                dlt_q[j] <= '0;
                tht_q[j] <= '0;
            end
            gam_q  <= W'(1);
            k_q    <= '0;
            cnt_q  <= '0;
            tag_q  <= '0;
            zro_q  <= 1'b0;
            osig_q <= '0;
            oom_q  <= '0;
            odeg_q <= '0;
            otag_q <= '0;
            ozro_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            lam_q  <= lam_d;
            b_q    <= b_d;
            dlt_q  <= dlt_d;
            tht_q  <= tht_d;
            gam_q  <= gam_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            tag_q  <= tag_d;
            zro_q  <= zro_d;
            osig_q <= osig_d;
            oom_q  <= oom_d;
            odeg_q <= odeg_d;
            otag_q <= otag_d;
            ozro_q <= ozro_d;
            ovld_q <= ovld_d;
        end
    end

    assign sigma_o     = osig_q;
    assign omega_o     = oom_q;
    assign deg_o       = odeg_q;
    assign tag_o       = otag_q;
    assign zero_o      = ozro_q;
    assign out_valid_o = ovld_q;

endmodule

// File: tb/tb_ribm_solver_pipe.sv
// tb_ribm_solver_pipe: randomized bench for ribm_solver_pipe.
// Reference: locator from known error positions, evaluator from syndromes.
module tb_ribm_solver_pipe;
    localparam int T     = 11;
    localparam int W     = 10;
    localparam int TAG_W = 8;
    localparam int N     = 2 * T;
    localparam int DW    = $clog2(T + 1);
    localparam int Q     = 1023;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [(N+1)*W-1:0] syn = '0;
    logic [TAG_W-1:0]   tag = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic               in_ready, out_valid, busy, zero;
    logic [(T+1)*W-1:0] sigma;
    logic [T*W-1:0]     omega;
    logic [DW-1:0]      deg;
    logic [TAG_W-1:0]   tag_out;

    int n_vec = 0;
    int n_err = 0;
    int exp_t [0:Q-1];
    int log_t [0:Q];
    int m_syn [0:1][0:N];
    int m_sig [0:1][0:T];
    int m_om  [0:1][0:T-1];
    int m_tag [0:1];
    int m_ne  [0:1];

    ribm_solver_pipe #(
        .T(T), .W(W), .POLY(10'h009), .KW(6), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .syn_i(syn), .tag_i(tag),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sigma_o(sigma), .omega_o(omega), .deg_o(deg), .zero_o(zero),
        .tag_o(tag_out), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % Q];
    endfunction

    function automatic int sg(input int i);
        return int'(sigma[i*W +: W]);
    endfunction

    function automatic int om(input int i);
        return int'(omega[i*W +: W]);
    endfunction

    task automatic init_gf();
        int a = 1;
        for (int i = 0; i < Q; i++) begin
            exp_t[i] = a;
            log_t[a] = i;
            a = a << 1;
            if ((a & 1024) != 0) a = a ^ 'h409;
        end
    endtask

    // Build syndromes, locator and evaluator for a codeword with ne errors
    task automatic gen(input int s, input int ne, input bit unit);
        int pos [0:T-1];
        int val [0:T-1];
        bit dup;
        for (int e = 0; e < ne; e++) begin
            do begin
                pos[e] = unit ? 0 : int'($urandom_range(0, Q - 1));
                dup = 1'b0;
                for (int f = 0; f < e; f++) if (pos[f] == pos[e]) dup = 1'b1;
            end while (dup);
            val[e] = unit ? 1 : int'($urandom_range(1, Q));
        end
        m_syn[s][0] = 0;
        for (int j = 1; j <= N; j++) begin
            m_syn[s][j] = 0;
            for (int e = 0; e < ne; e++)
                m_syn[s][j] ^= gmul(val[e], exp_t[(pos[e] * j) % Q]);
        end
        for (int i = 0; i <= T; i++) m_sig[s][i] = (i == 0) ? 1 : 0;
        for (int e = 0; e < ne; e++)
            for (int i = T; i >= 1; i--)
                m_sig[s][i] ^= gmul(exp_t[pos[e]], m_sig[s][i-1]);
        for (int i = 0; i < T; i++) begin
            m_om[s][i] = 0;
            for (int j = i + 1; j <= T; j++)
                m_om[s][i] ^= gmul(m_sig[s][j], m_syn[s][i + N - j + 1]);
        end
        m_tag[s] = int'($urandom_range(0, 255));
        m_ne[s]  = ne;
    endtask

    task automatic send(input int s);
        int w = 0;
        syn[W-1:0] = W'($urandom);
        for (int j = 1; j <= N; j++) syn[j*W +: W] = W'(m_syn[s][j]);
        tag      = TAG_W'(m_tag[s]);
        in_valid = 1'b1;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready_o=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_in_ready: got %0b want 0", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL rst_busy: got %0b want 0", busy);
        end
        n_vec++;
        if ({sigma, omega, deg, zero, tag_out} !== '0) begin
            n_err++; $display("FAIL rst_outputs: got %h want 0", {sigma, omega, deg, zero, tag_out});
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_rst: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_zero();
        int cyc;
        int lat;
`ifdef RIBM_ZERO_BYPASS_EN
        lat = 1;
`else
        lat = N;
`endif
        gen(0, 0, 1'b0);
        m_tag[0] = 'h5A;
        out_ready = 1'b1;
        send(0);
        wait_valid(cyc);
        n_vec++;
        if (cyc != lat) begin
            n_err++; $display("FAIL zero_latency: got %0d want %0d", cyc, lat);
        end
        n_vec++;
        if (sg(0) == 0) begin
            n_err++; $display("FAIL zero_sigma0: got 0 want nonzero");
        end
        for (int i = 1; i <= T; i++) begin
            n_vec++;
            if (sg(i) != 0) begin
                n_err++; $display("FAIL zero_sigma[%0d]: got %0h want 0", i, sg(i));
            end
        end
        n_vec++;
        if (deg !== '0) begin
            n_err++; $display("FAIL zero_deg: got %0d want 0", deg);
        end
        n_vec++;
        if (zero !== 1'b1) begin
            n_err++; $display("FAIL zero_flag: got %0b want 1", zero);
        end
        n_vec++;
        if (tag_out !== 8'h5A) begin
            n_err++; $display("FAIL zero_tag: got %0h want 5a", tag_out);
        end
    endtask

    task automatic test_single();
        int cyc;
        drain();
        gen(0, 1, 1'b1);
        send(0);
        wait_valid(cyc);
        n_vec++;
        if (cyc != N) begin
            n_err++; $display("FAIL single_latency: got %0d want %0d", cyc, N);
        end
        n_vec++;
        if (sg(0) == 0 || sg(1) != sg(0)) begin
            n_err++; $display("FAIL single_sigma01: got %0h,%0h want equal nonzero", sg(0), sg(1));
        end
        for (int i = 2; i <= T; i++) begin
            n_vec++;
            if (sg(i) != 0) begin
                n_err++; $display("FAIL single_sigma[%0d]: got %0h want 0", i, sg(i));
            end
        end
        n_vec++;
        if (deg !== DW'(1)) begin
            n_err++; $display("FAIL single_deg: got %0d want 1", deg);
        end
        n_vec++;
        if (zero !== 1'b0) begin
            n_err++; $display("FAIL single_zero: got %0b want 0", zero);
        end
    endtask

    task automatic test_random();
        int cyc;
        int s0;
        int ne;
        drain();
        for (int r = 0; r < 8; r++) begin
            ne = (r < 4) ? T : int'($urandom_range(1, T));
            gen(0, ne, 1'b0);
            send(0);
            wait_valid(cyc);
            s0 = sg(0);
            n_vec++;
            if (cyc != N || s0 == 0) begin
                n_err++; $display("FAIL rnd%0d_lat_s0: got lat %0d s0 %0h want %0d nonzero", r, cyc, s0, N);
            end
            for (int i = 1; i <= T; i++) begin
                n_vec++;
                if (sg(i) != gmul(m_sig[0][i], s0)) begin
                    n_err++; $display("FAIL rnd%0d_sigma[%0d]: got %0h want %0h", r, i, sg(i), gmul(m_sig[0][i], s0));
                end
            end
            for (int i = 0; i < T; i++) begin
                n_vec++;
                if (om(i) != gmul(m_om[0][i], s0)) begin
                    n_err++; $display("FAIL rnd%0d_omega[%0d]: got %0h want %0h", r, i, om(i), gmul(m_om[0][i], s0));
                end
            end
            n_vec++;
            if (int'(deg) != ne || zero !== 1'b0 || int'(tag_out) != m_tag[0]) begin
                n_err++; $display("FAIL rnd%0d_deg_zero_tag: got %0d/%0b/%0h want %0d/0/%0h", r, deg, zero, tag_out, ne, m_tag[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int s0;
        drain();
        out_ready = 1'b0;
        gen(0, T, 1'b0);
        gen(1, T, 1'b0);
        send(0);
        wait_valid(cyc);
        n_vec++;
        if (cyc != N) begin
            n_err++; $display("FAIL bp_first_latency: got %0d want %0d", cyc, N);
        end
        send(1);
        repeat (N + 4) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_stall: got busy %0b rdy %0b vld %0b want 1 0 1", busy, in_ready, out_valid);
        end
        n_vec++;
        if (int'(tag_out) != m_tag[0]) begin
            n_err++; $display("FAIL bp_tag1: got %0h want %0h", tag_out, m_tag[0]);
        end
        s0 = sg(0);
        for (int i = 1; i <= T; i++) begin
            n_vec++;
            if (sg(i) != gmul(m_sig[0][i], s0)) begin
                n_err++; $display("FAIL bp_res1_sigma[%0d]: got %0h want %0h", i, sg(i), gmul(m_sig[0][i], s0));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b1 || int'(tag_out) != m_tag[1] || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_res2: got vld %0b tag %0h busy %0b want 1 %0h 0", out_valid, tag_out, busy, m_tag[1]);
        end
        s0 = sg(0);
        for (int i = 1; i <= T; i++) begin
            n_vec++;
            if (sg(i) != gmul(m_sig[1][i], s0)) begin
                n_err++; $display("FAIL bp_res2_sigma[%0d]: got %0h want %0h", i, sg(i), gmul(m_sig[1][i], s0));
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        int seen = 0;
        drain();
        out_ready = 1'b0;
        gen(0, T, 1'b0);
        gen(1, T, 1'b0);
        send(0);
        wait_valid(cyc);
        send(1);
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_busy_before: got %0b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rst: got busy %0b vld %0b rdy %0b want 0 0 1", busy, out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (N + 8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL mid_no_result: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_same_edge();
        int cyc;
        int s0;
        drain();
        out_ready = 1'b0;
        gen(0, T, 1'b0);
        gen(1, T, 1'b0);
        send(0);
        wait_valid(cyc);
        send(1);
        repeat (N - 1) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || int'(tag_out) != m_tag[0] || busy !== 1'b1) begin
            n_err++; $display("FAIL se_before: got vld %0b tag %0h busy %0b want 1 %0h 1", out_valid, tag_out, busy, m_tag[0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b1 || int'(tag_out) != m_tag[1] || busy !== 1'b0) begin
            n_err++; $display("FAIL se_after: got vld %0b tag %0h busy %0b want 1 %0h 0", out_valid, tag_out, busy, m_tag[1]);
        end
        s0 = sg(0);
        for (int i = 0; i < T; i++) begin
            n_vec++;
            if (om(i) != gmul(m_om[1][i], s0)) begin
                n_err++; $display("FAIL se_omega[%0d]: got %0h want %0h", i, om(i), gmul(m_om[1][i], s0));
            end
        end
        n_vec++;
        if (int'(deg) != T) begin
            n_err++; $display("FAIL se_deg: got %0d want %0d", deg, T);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL se_drain: got %0b want 0", out_valid);
        end
    endtask

    initial begin
        init_gf();
        test_reset();
        test_zero();
        test_single();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        test_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
